// File: rtl/tx_ipv4.sv
// rtl/tx_ipv4.sv - IPv4 transmit framer: 20-byte header generation followed by payload forwarding
//
// Build option: define TX_IPV4_CSUM_EN to compute the header checksum (adds CSUM and
// FOLD states, 11 extra cycles of start latency). Without it the checksum field is 0.
//
// Ports:
//   TX_CLK, rst_n      clock, synchronous active-low reset
//   func_en            block enable; all state and outputs hold while low
//   ip_addr            local source address, latched at an accepted start
//   tx_dst_ip, tx_protocol, tx_tos, tx_payload_len, tx_start
//                      send request, fields latched when tx_start is accepted
//   tx_busy            high from accepted start until the packet completes
//   tx_err             one-cycle pulse when a start is rejected for length
//   tx_ipv4_irq        one-cycle pulse after the last byte has been accepted
//   tx_udp_data_v/tx_udp_data/tx_udp_ready      payload byte input handshake
//   tx_ipv4_data_v/tx_ipv4_data/tx_ipv4_ready   framed byte output handshake
module tx_ipv4 #(
  parameter int          OCT         = 8,
  parameter logic [7:0]  TTL         = 8'h40,
  parameter logic [15:0] MAX_PAYLOAD = 16'd1480
) (
  input  logic           TX_CLK,
  input  logic           rst_n,
  input  logic           func_en,
  input  logic [31:0]    ip_addr,
  input  logic [31:0]    tx_dst_ip,
  input  logic [7:0]     tx_protocol,
  input  logic [7:0]     tx_tos,
  input  logic [15:0]    tx_payload_len,
  input  logic           tx_start,
  output logic           tx_busy,
  output logic           tx_err,
  output logic           tx_ipv4_irq,
  input  logic           tx_udp_data_v,
  input  logic [OCT-1:0] tx_udp_data,
  output logic           tx_udp_ready,
  output logic           tx_ipv4_data_v,
  output logic [OCT-1:0] tx_ipv4_data,
  input  logic           tx_ipv4_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSUM,
    S_FOLD,
    S_HEADER,
    S_DATA,
    S_DONE
  } state_t;

  state_t      state;
  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [7:0]  proto_q;
  logic [7:0]  tos_q;
  logic [15:0] tot_q;
  logic [15:0] cnt_q;
  logic [15:0] id_q;
  logic [15:0] csum_q;
  logic [4:0]  byte_idx;
  logic [3:0]  hidx;
  logic [15:0] hword;
  logic [7:0]  hbyte;
  logic        out_load;
  logic        udp_take;

`ifdef TX_IPV4_CSUM_EN
  logic [19:0] acc_q;
  logic [3:0]  word_idx;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // End-around carry: the 4-bit overflow is added back, and the carry that
  // this addition may produce is added back once more.
  assign fold1 = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

  // The same word mux serves the checksum walk and the byte serialiser.
  assign hidx = (state == S_CSUM) ? word_idx : byte_idx[4:1];
`else
  assign hidx = byte_idx[4:1];
`endif

  // csum_q is cleared at start, so word 5 contributes 0 to its own sum.
  always_comb begin
    hword = 16'h0000;
    case (hidx)
      4'd0:    hword = 16'h4500 | {8'h00, tos_q};
      4'd1:    hword = tot_q;
      4'd2:    hword = id_q;
      4'd3:    hword = 16'h4000;
      4'd4:    hword = {TTL, proto_q};
      4'd5:    hword = csum_q;
      4'd6:    hword = src_q[31:16];
      4'd7:    hword = src_q[15:0];
      4'd8:    hword = dst_q[31:16];
      4'd9:    hword = dst_q[15:0];
      default: hword = 16'h0000;
    endcase
  end

  assign hbyte    = byte_idx[0] ? hword[7:0] : hword[15:8];
  // Output register may take a new byte when empty or when its byte leaves now.
  assign out_load = !tx_ipv4_data_v || tx_ipv4_ready;
  // No payload is pulled once the counted length has been taken.
  assign tx_udp_ready = func_en && (state == S_DATA) && (cnt_q != 16'd0) && out_load;
  assign udp_take     = tx_udp_data_v && tx_udp_ready;

  always_ff @(posedge TX_CLK) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      tx_busy        <= 1'b0;
      tx_err         <= 1'b0;
      tx_ipv4_irq    <= 1'b0;
      tx_ipv4_data_v <= 1'b0;
      tx_ipv4_data   <= '0;
      src_q          <= 32'd0;
      dst_q          <= 32'd0;
      proto_q        <= 8'd0;
      tos_q          <= 8'd0;
      tot_q          <= 16'd0;
      cnt_q          <= 16'd0;
      id_q           <= 16'd0;
      csum_q         <= 16'd0;
      byte_idx       <= 5'd0;
`ifdef TX_IPV4_CSUM_EN
      acc_q          <= 20'd0;
      word_idx       <= 4'd0;
`endif
    end else if (func_en) begin
      tx_err      <= 1'b0;
      tx_ipv4_irq <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_start) begin
            if (tx_payload_len > MAX_PAYLOAD) begin
              tx_err <= 1'b1;
            end else begin
              src_q    <= ip_addr;
              dst_q    <= tx_dst_ip;
              proto_q  <= tx_protocol;
              tos_q    <= tx_tos;
              tot_q    <= tx_payload_len + 16'd20;
              cnt_q    <= tx_payload_len;
              csum_q   <= 16'd0;
              byte_idx <= 5'd0;
              tx_busy  <= 1'b1;
`ifdef TX_IPV4_CSUM_EN
              acc_q    <= 20'd0;
              word_idx <= 4'd0;
              state    <= S_CSUM;
`else
              state    <= S_HEADER;
`endif
            end
          end
        end

`ifdef TX_IPV4_CSUM_EN
        S_CSUM: begin
          acc_q    <= acc_q + {4'd0, hword};
          word_idx <= word_idx + 4'd1;
          if (word_idx == 4'd9) state <= S_FOLD;
        end

        S_FOLD: begin
          csum_q <= ~fold2;
          state  <= S_HEADER;
        end
`endif

        S_HEADER: begin
          if (out_load) begin
            tx_ipv4_data   <= hbyte;
            tx_ipv4_data_v <= 1'b1;
            byte_idx       <= byte_idx + 5'd1;
            if (byte_idx == 5'd19) state <= S_DATA;
          end
        end

        S_DATA: begin
          if (out_load) begin
            if (udp_take) begin
              tx_ipv4_data   <= tx_udp_data;
              tx_ipv4_data_v <= 1'b1;
              cnt_q          <= cnt_q - 16'd1;
            end else begin
              tx_ipv4_data_v <= 1'b0;
            end
            // With the count exhausted, out_load means the last byte is gone.
            if (cnt_q == 16'd0) state <= S_DONE;
          end
        end

        S_DONE: begin
          tx_ipv4_irq <= 1'b1;
          tx_busy     <= 1'b0;
          id_q        <= id_q + 16'd1;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_ipv4.sv
// tb/tb_tx_ipv4.sv - self-checking testbench for tx_ipv4
module tb_tx_ipv4;

  logic        TX_CLK = 1'b0;
  logic        rst_n;
  logic        func_en;
  logic [31:0] ip_addr;
  logic [31:0] tx_dst_ip;
  logic [7:0]  tx_protocol;
  logic [7:0]  tx_tos;
  logic [15:0] tx_payload_len;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_err;
  logic        tx_ipv4_irq;
  logic        tx_udp_data_v;
  logic [7:0]  tx_udp_data;
  logic        tx_udp_ready;
  logic        tx_ipv4_data_v;
  logic [7:0]  tx_ipv4_data;
  logic        tx_ipv4_ready;

  always #5 TX_CLK = ~TX_CLK;

  tx_ipv4 dut (
    .TX_CLK         (TX_CLK),
    .rst_n          (rst_n),
    .func_en        (func_en),
    .ip_addr        (ip_addr),
    .tx_dst_ip      (tx_dst_ip),
    .tx_protocol    (tx_protocol),
    .tx_tos         (tx_tos),
    .tx_payload_len (tx_payload_len),
    .tx_start       (tx_start),
    .tx_busy        (tx_busy),
    .tx_err         (tx_err),
    .tx_ipv4_irq    (tx_ipv4_irq),
    .tx_udp_data_v  (tx_udp_data_v),
    .tx_udp_data    (tx_udp_data),
    .tx_udp_ready   (tx_udp_ready),
    .tx_ipv4_data_v (tx_ipv4_data_v),
    .tx_ipv4_data   (tx_ipv4_data),
    .tx_ipv4_ready  (tx_ipv4_ready)
  );

`ifdef TX_IPV4_CSUM_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [7:0]  proto;
    logic [7:0]  tos;
    logic [15:0] len;
    logic [15:0] id;
    logic [15:0] csum;
    int          rmode;
    int          umode;
    bit          poke;
  } vec_t;

  vec_t vecs[6];
  bit   rpat[7];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pay(input int seed, input int i);
    return 8'(i * 37 + seed * 11 + 5);
  endfunction

  function automatic logic [7:0] exp_hdr(input vec_t v, input int i);
    logic [15:0] w;
    logic [15:0] cs;
`ifdef TX_IPV4_CSUM_EN
    cs = v.csum;
`else
    cs = 16'h0000;
`endif
    case (i / 2)
      0:       w = 16'h4500 | {8'h00, v.tos};
      1:       w = v.len + 16'd20;
      2:       w = v.id;
      3:       w = 16'h4000;
      4:       w = {8'h40, v.proto};
      5:       w = cs;
      6:       w = v.src[31:16];
      7:       w = v.src[15:0];
      8:       w = v.dst[31:16];
      default: w = v.dst[15:0];
    endcase
    return (i % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  task automatic run_pkt(input vec_t v, input string tag);
    logic [7:0] got[$];
    logic [7:0] prev_data;
    logic [31:0] act;
    int  sent, cyc, first_v, irqs, holds;
    bit  prev_stall, done;
    ip_addr        = v.src;
    tx_dst_ip      = v.dst;
    tx_protocol    = v.proto;
    tx_tos         = v.tos;
    tx_payload_len = v.len;
    tx_start       = 1'b1;
    @(posedge TX_CLK); #1;
    tx_start = 1'b0;
    chk($sformatf("%s_busy_start", tag), 32'(tx_busy), 32'd1);
    sent = 0; cyc = 0; first_v = -1; irqs = 0; holds = 0;
    prev_stall = 1'b0; prev_data = 8'h00; done = 1'b0;
    while (!done && cyc < 3000) begin
      tx_ipv4_ready = (v.rmode == 0) ? 1'b1 : rpat[cyc % 7];
      tx_udp_data_v = (sent < int'(v.len)) && !(v.umode == 1 && cyc % 3 == 0);
      tx_udp_data   = pay(int'(v.id), sent);
      if (v.poke && cyc == 3) begin
        tx_start       = 1'b1;
        tx_payload_len = 16'd5;
        tx_dst_ip      = 32'h01020304;
      end
      #1;
      if (tx_ipv4_irq) irqs++;
      if (first_v < 0 && tx_ipv4_data_v) first_v = cyc;
      if (prev_stall && (!tx_ipv4_data_v || tx_ipv4_data !== prev_data)) holds++;
      prev_stall = tx_ipv4_data_v && !tx_ipv4_ready;
      prev_data  = tx_ipv4_data;
      if (tx_ipv4_data_v && tx_ipv4_ready) got.push_back(tx_ipv4_data);
      if (tx_udp_data_v && tx_udp_ready) sent++;
      if (irqs > 0) done = 1'b1;
      @(posedge TX_CLK); #1;
      tx_start = 1'b0;
      cyc++;
    end
    tx_udp_data_v = 1'b0;
    tx_ipv4_ready = 1'b1;
    chk($sformatf("%s_completed", tag), 32'(done), 32'd1);
    chk($sformatf("%s_busy_after", tag), 32'(tx_busy), 32'd0);
    repeat (3) begin
      if (tx_ipv4_irq) irqs++;
      @(posedge TX_CLK); #1;
    end
    chk($sformatf("%s_irq_count", tag), 32'(irqs), 32'd1);
    chk($sformatf("%s_latency", tag), 32'(first_v), 32'(LAT));
    chk($sformatf("%s_byte_count", tag), 32'(got.size()), 32'(int'(v.len) + 20));
    chk($sformatf("%s_payload_taken", tag), 32'(sent), 32'(v.len));
    chk($sformatf("%s_hold_violations", tag), 32'(holds), 32'd0);
    for (int i = 0; i < 20; i++) begin
      act = (i < got.size()) ? 32'(got[i]) : 32'hxxxxxxxx;
      chk($sformatf("%s_hdr%0d", tag, i), act, 32'(exp_hdr(v, i)));
    end
    for (int i = 0; i < int'(v.len); i++) begin
      act = (i + 20 < got.size()) ? 32'(got[i + 20]) : 32'hxxxxxxxx;
      chk($sformatf("%s_pay%0d", tag, i), act, 32'(pay(int'(v.id), i)));
    end
  endtask

  initial begin
    int n, sent, cyc, cnt_v, cnt_e, cnt_i;

    rpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    //          src           dst           prot   tos    len        id      csum     r  u  poke
    vecs[0] = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 8'h00, 16'd95,   16'd0, 16'hB861, 0, 0, 1'b0};
    vecs[1] = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 8'h00, 16'd95,   16'd1, 16'hB860, 0, 0, 1'b0};
    vecs[2] = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 8'h00, 16'd8,    16'd2, 16'hB8B6, 1, 0, 1'b1};
    vecs[3] = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 8'h00, 16'd0,    16'd3, 16'hB8BD, 0, 0, 1'b0};
    vecs[4] = '{32'h0A000001, 32'h0A000002, 8'h06, 8'hB8, 16'd3,    16'd4, 16'h2623, 1, 1, 1'b0};
    vecs[5] = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 8'h00, 16'd1480, 16'd5, 16'hB2F3, 0, 0, 1'b0};

    rst_n = 1'b0; func_en = 1'b1; ip_addr = 32'd0; tx_dst_ip = 32'd0;
    tx_protocol = 8'd0; tx_tos = 8'd0; tx_payload_len = 16'd0; tx_start = 1'b0;
    tx_udp_data_v = 1'b0; tx_udp_data = 8'd0; tx_ipv4_ready = 1'b1;
    repeat (3) @(posedge TX_CLK);
    #1;
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_err", 32'(tx_err), 32'd0);
    chk("rst_irq", 32'(tx_ipv4_irq), 32'd0);
    chk("rst_data_v", 32'(tx_ipv4_data_v), 32'd0);
    chk("rst_data", 32'(tx_ipv4_data), 32'd0);
    chk("rst_udp_ready", 32'(tx_udp_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge TX_CLK); #1;

    for (int k = 0; k < 6; k++) run_pkt(vecs[k], $sformatf("v%0d", k));

    // Oversize request: rejected with a single tx_err pulse and no output.
    tx_payload_len = 16'd1481;
    tx_start       = 1'b1;
    @(posedge TX_CLK); #1;
    tx_start = 1'b0;
    chk("err_pulse", 32'(tx_err), 32'd1);
    chk("err_busy", 32'(tx_busy), 32'd0);
    cnt_v = 0; cnt_e = 0;
    repeat (20) begin
      @(posedge TX_CLK); #1;
      if (tx_ipv4_data_v) cnt_v++;
      if (tx_err || tx_busy) cnt_e++;
    end
    chk("err_no_output", 32'(cnt_v), 32'd0);
    chk("err_single_cycle", 32'(cnt_e), 32'd0);

    // Reset while the third payload byte is being accepted.
    ip_addr = 32'hC0A80001; tx_dst_ip = 32'hC0A800C7; tx_protocol = 8'h11;
    tx_tos = 8'h00; tx_payload_len = 16'd10; tx_start = 1'b1;
    @(posedge TX_CLK); #1;
    tx_start = 1'b0;
    n = 0; sent = 0; cyc = 0;
    while (n < 23 && cyc < 200) begin
      tx_ipv4_ready = 1'b1;
      tx_udp_data_v = 1'b1;
      tx_udp_data   = 8'(sent);
      #1;
      if (tx_ipv4_data_v && tx_ipv4_ready) n++;
      if (tx_udp_data_v && tx_udp_ready) sent++;
      if (n < 23) begin
        @(posedge TX_CLK); #1;
        cyc++;
      end
    end
    chk("rstmid_reached", 32'(n), 32'd23);
    rst_n = 1'b0;
    @(posedge TX_CLK); #1;
    chk("rstmid_data_v", 32'(tx_ipv4_data_v), 32'd0);
    chk("rstmid_busy", 32'(tx_busy), 32'd0);
    rst_n = 1'b1;
    tx_udp_data_v = 1'b0;
    cnt_i = 0;
    repeat (20) begin
      if (tx_ipv4_irq) cnt_i++;
      @(posedge TX_CLK); #1;
    end
    chk("rstmid_no_irq", 32'(cnt_i), 32'd0);

    // ID counter restarts at zero after reset.
    run_pkt(vecs[0], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
